// File: rtl/tiger_ifetch_pkg.sv
// tiger_ifetch_pkg: shared defaults and state encoding for the instruction fetch unit
package tiger_ifetch_pkg;
  localparam int IFETCH_DEPTH = 2;
  localparam int IFETCH_AW = 32;
  typedef enum logic {IF_RUN = 1'b0, IF_DRAIN = 1'b1} if_state_e;
endpackage

// File: rtl/tiger_ifetch_if.sv
// tiger_ifetch_if: fetch request, Avalon-MM instruction read and decode delivery signals
interface tiger_ifetch_if #(parameter int AW = 32);
  logic [AW-1:0] req_pc;
  logic req_valid;
  logic req_ready;
  logic flush;
  logic [AW-1:0] iaddress;
  logic iread;
  logic iwaitrequest;
  logic [31:0] ireaddata;
  logic ireaddatavalid;
  logic [31:0] instr;
  logic [AW-1:0] instr_pc;
  logic instr_valid;
  logic instr_ready;
  modport master (
    input req_pc, req_valid, flush, iwaitrequest, ireaddata, ireaddatavalid, instr_ready,
    output req_ready, iaddress, iread, instr, instr_pc, instr_valid
  );
  modport slave (
    output req_pc, req_valid, flush, iwaitrequest, ireaddata, ireaddatavalid, instr_ready,
    input req_ready, iaddress, iread, instr, instr_pc, instr_valid
  );
endinterface

// File: rtl/tiger_ifetch_sync_fifo.sv
// tiger_sync_fifo: synchronous FIFO with clear; push while full is taken only alongside a pop
module tiger_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  logic pop_i,
  input  logic clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic full_o,
  output logic empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [PW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == (PW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o = mem_q[rd_q];
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || pop_i);
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_q + PW'(do_pop);
      wr_q <= wr_q + PW'(do_push);
      cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/tiger_ifetch.sv
// tiger_ifetch: pipelined Avalon instruction fetch with PC tagging, in-order delivery and flush drain
module tiger_ifetch
  import tiger_ifetch_pkg::*;
#(
  parameter int DEPTH = IFETCH_DEPTH,
  parameter int AW = IFETCH_AW
) (
  input logic clk,
  input logic reset,
  tiger_ifetch_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  if_state_e state_q, state_d;
  logic [CW-1:0] inflight_q, inflight_d, discard_q, discard_d;
  logic iread_q, iread_d;
  logic [AW-1:0] iaddress_q, iaddress_d;
  logic [CW-1:0] out_count, tag_count;
  logic [AW-1:0] tag_pc;
  logic [AW+31:0] out_data;
  logic out_empty, out_full, tag_empty, tag_full;
  logic req_ready, issue, acc, rv_ok, live_rv, credit, draining;
  always_comb begin
    acc = iread_q && !bus.iwaitrequest;
    credit = ({1'b0, inflight_q} + {1'b0, out_count} + (CW+1)'(iread_q)) < (CW+1)'(DEPTH);
    req_ready = !reset && !bus.flush && state_q == IF_RUN && credit && (!iread_q || !bus.iwaitrequest);
    issue = bus.req_valid && req_ready;
    rv_ok = bus.ireaddatavalid && inflight_q != '0;
    live_rv = rv_ok && state_q == IF_RUN;
    inflight_d = inflight_q + CW'(acc) - CW'(rv_ok);
    iread_d = issue || (iread_q && !acc);
    iaddress_d = issue ? bus.req_pc : iaddress_q;
    discard_d = bus.flush ? inflight_d
              : state_q == IF_DRAIN ? discard_q + CW'(acc) - CW'(rv_ok) : '0;
    draining = bus.flush || state_q == IF_DRAIN;
    // a stalled read left over from a flush keeps us draining until its data is dropped
    state_d = draining && (discard_d != '0 || iread_d) ? IF_DRAIN : IF_RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IF_RUN;
      iread_q <= 1'b0;
      iaddress_q <= '0;
      inflight_q <= '0;
      discard_q <= '0;
    end else begin
      state_q <= state_d;
      iread_q <= iread_d;
      iaddress_q <= iaddress_d;
      inflight_q <= inflight_d;
      discard_q <= discard_d;
    end
  end
  tiger_sync_fifo #(.WIDTH(AW), .DEPTH(DEPTH)) u_tag (
    .clk(clk), .reset(reset), .push_i(issue), .pop_i(live_rv), .clear_i(bus.flush),
    .data_i(bus.req_pc), .data_o(tag_pc), .full_o(tag_full), .empty_o(tag_empty), .count_o(tag_count)
  );
  tiger_sync_fifo #(.WIDTH(AW + 32), .DEPTH(DEPTH)) u_out (
    .clk(clk), .reset(reset), .push_i(live_rv), .pop_i(bus.instr_ready), .clear_i(bus.flush),
    .data_i({tag_pc, bus.ireaddata}), .data_o(out_data), .full_o(out_full), .empty_o(out_empty),
    .count_o(out_count)
  );
  assign bus.req_ready = req_ready;
  assign bus.iread = iread_q;
  assign bus.iaddress = iaddress_q;
  assign bus.instr_valid = !out_empty;
  assign bus.instr = out_empty ? '0 : out_data[31:0];
  assign bus.instr_pc = out_empty ? '0 : out_data[AW+31:32];
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!bus.ireaddatavalid || inflight_q != '0);
      assert (!(issue && tag_full));
      assert (!(live_rv && (tag_empty || (out_full && !bus.instr_ready))));
      assert (state_q != IF_RUN || tag_count == inflight_q + CW'(iread_q));
    end
  end
endmodule

// File: tb/tb_tiger_ifetch.sv
// tb_tiger_ifetch: directed and randomized checks of tiger_ifetch against a fetch-stream reference model
module tb_tiger_ifetch;
  localparam int DEPTH = 4;
  localparam int AW = 32;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  tiger_ifetch_if #(.AW(AW)) bus();
  tiger_ifetch #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));
  int cmp = 0, bad = 0, cyc = 0, lat = 1, n_acc = 0, n_issue = 0, dead = 0, outstanding = 0;
  logic [AW-1:0] exp_q[$], bus_q[$], mem_a[$];
  int mem_due[$], dcyc[$];
  logic did_issue = 1'b0, hold_v = 1'b0;
  logic [AW-1:0] hold_a = '0;
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'h1000 + a[31:0];
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic rr, rv, acc, dlv;
    logic [AW-1:0] pc;
    bus.ireaddatavalid = 1'b0;
    bus.ireaddata = '0;
    if (!reset && mem_a.size() != 0 && mem_due[0] <= cyc) begin
      bus.ireaddatavalid = 1'b1;
      bus.ireaddata = mem_word(mem_a[0]);
    end
    #1;
    rr = bus.req_ready;
    rv = bus.ireaddatavalid;
    acc = bus.iread && !bus.iwaitrequest;
    dlv = bus.instr_valid && bus.instr_ready && !bus.flush;
    did_issue = bus.req_valid && rr;
    if (reset) begin
      exp_q.delete(); bus_q.delete(); mem_a.delete(); mem_due.delete();
      dead = 0; outstanding = 0; hold_v = 1'b0; did_issue = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_iread", bus.iread, 1'b1);
        chk("hold_iaddress", bus.iaddress, hold_a);
      end
      hold_v = bus.iread && bus.iwaitrequest;
      hold_a = bus.iaddress;
      if (dead > 0 || bus.flush) chk("no_issue_ready", rr, 1'b0);
      if (acc) begin
        chk("bus_read_expected", bus_q.size() != 0, 1'b1);
        if (bus_q.size() != 0) chk("bus_addr", bus.iaddress, bus_q.pop_front());
        n_acc++;
        mem_a.push_back(bus.iaddress);
        mem_due.push_back(cyc + lat);
      end
      if (rv) begin
        void'(mem_a.pop_front());
        void'(mem_due.pop_front());
        outstanding--;
        if (dead > 0) dead--;
      end
      if (dlv) begin
        chk("deliver_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          pc = exp_q.pop_front();
          chk("instr_pc", bus.instr_pc, pc);
          chk("instr", bus.instr, mem_word(pc));
        end
        dcyc.push_back(cyc);
      end
      if (bus.flush) begin
        exp_q.delete();
        dead = outstanding;
      end
      if (did_issue) begin
        exp_q.push_back(bus.req_pc);
        bus_q.push_back(bus.req_pc);
        outstanding++;
        n_issue++;
        chk("credit_limit", exp_q.size() <= DEPTH, 1'b1);
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask
  task automatic settle();
    logic done;
    done = 1'b0;
    bus.req_valid = 1'b0; bus.flush = 1'b0; bus.instr_ready = 1'b1; bus.iwaitrequest = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      tick();
      done = exp_q.size() == 0 && mem_a.size() == 0 && !bus.iread && !bus.instr_valid && dead == 0;
    end
    chk("settle", done, 1'b1);
  endtask
  initial begin
    int c0, a0, i0, d0, nv;
    logic [AW-1:0] pc;
    logic ok;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_pc = '0; bus.flush = 1'b0; bus.instr_ready = 1'b1;
    bus.iwaitrequest = 1'b0; bus.ireaddata = '0; bus.ireaddatavalid = 1'b0;
    @(negedge clk);
    tick(); tick();
    #1;
    chk("rst_iread", bus.iread, 1'b0);
    chk("rst_iaddress", bus.iaddress, 32'h0);
    chk("rst_instr_valid", bus.instr_valid, 1'b0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    chk("rst_req_ready", bus.req_ready, 1'b0);
    reset = 1'b0;
    #1 chk("post_rst_ready", bus.req_ready, 1'b1);
    // zero-wait stream, one instruction per cycle from the third cycle after the first request
    lat = 1; dcyc.delete(); c0 = cyc; bus.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_pc = 32'(4 * i);
      tick();
      chk("stream_issue", did_issue, 1'b1);
    end
    bus.req_valid = 1'b0;
    repeat (5) tick();
    chk("stream_count", dcyc.size(), 4);
    for (int i = 0; i < dcyc.size(); i++) chk("stream_cycle", dcyc[i], c0 + 3 + i);
    // waitrequest holds the read
    settle();
    bus.iwaitrequest = 1'b1; bus.req_valid = 1'b1; bus.req_pc = 32'h40;
    tick();
    chk("wait_issue", did_issue, 1'b1);
    bus.req_valid = 1'b0; a0 = n_acc;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait_iaddress", bus.iaddress, 32'h40);
      chk("wait_iread", bus.iread, 1'b1);
      chk("wait_ready", bus.req_ready, 1'b0);
      tick();
    end
    chk("wait_no_accept", n_acc, a0);
    bus.iwaitrequest = 1'b0;
    repeat (3) tick();
    chk("wait_one_accept", n_acc, a0 + 1);
    // backpressure fills all credits
    settle();
    bus.instr_ready = 1'b0; pc = 32'h80; i0 = n_issue; bus.req_valid = 1'b1;
    repeat (10) begin
      bus.req_pc = pc;
      tick();
      if (did_issue) pc += 4;
    end
    chk("bp_issued", n_issue - i0, DEPTH);
    #1;
    chk("bp_ready_low", bus.req_ready, 1'b0);
    chk("bp_instr_valid", bus.instr_valid, 1'b1);
    bus.instr_ready = 1'b1; bus.req_pc = pc;
    #1 chk("bp_ready_pop_cycle", bus.req_ready, 1'b0);
    tick();
    #1 chk("bp_ready_after_pop", bus.req_ready, 1'b1);
    // flush with two reads in flight
    settle();
    lat = 5; bus.req_valid = 1'b1; bus.req_pc = 32'h100;
    tick();
    bus.req_pc = 32'h104;
    tick();
    bus.req_valid = 1'b0;
    tick();
    bus.flush = 1'b1;
    #1 chk("flush_ready", bus.req_ready, 1'b0);
    tick();
    bus.flush = 1'b0; nv = 0;
    repeat (8) begin
      #1 nv += int'(bus.instr_valid);
      tick();
    end
    chk("flush_no_valid", nv, 0);
    #1 chk("drain_exit_ready", bus.req_ready, 1'b1);
    lat = 1; bus.req_valid = 1'b1; bus.req_pc = 32'h200;
    tick();
    bus.req_valid = 1'b0; d0 = dcyc.size();
    repeat (5) tick();
    chk("post_flush_deliver", dcyc.size() - d0, 1);
    // flush while a read is stalled by waitrequest
    settle();
    bus.iwaitrequest = 1'b1; bus.req_valid = 1'b1; bus.req_pc = 32'h300;
    tick();
    bus.req_valid = 1'b0; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick();
    #1;
    chk("fw_iread", bus.iread, 1'b1);
    chk("fw_iaddress", bus.iaddress, 32'h300);
    chk("fw_ready", bus.req_ready, 1'b0);
    a0 = n_acc; d0 = dcyc.size(); ok = 1'b0; bus.iwaitrequest = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick();
      #1 ok = bus.req_ready;
    end
    chk("fw_accept", n_acc, a0 + 1);
    chk("fw_exit", ok, 1'b1);
    chk("fw_dropped", dcyc.size(), d0);
    // reset with one buffered and one in flight
    settle();
    bus.instr_ready = 1'b0; lat = 1; bus.req_valid = 1'b1; bus.req_pc = 32'h400;
    tick();
    bus.req_pc = 32'h404;
    tick();
    bus.req_valid = 1'b0; lat = 6;
    tick();
    #1 chk("pre_reset_valid", bus.instr_valid, 1'b1);
    reset = 1'b1;
    tick();
    #1;
    chk("mid_rst_valid", bus.instr_valid, 1'b0);
    chk("mid_rst_iread", bus.iread, 1'b0);
    chk("mid_rst_ready", bus.req_ready, 1'b0);
    reset = 1'b0;
    #1 chk("mid_rst_release_ready", bus.req_ready, 1'b1);
    bus.instr_ready = 1'b1; d0 = dcyc.size();
    repeat (10) tick();
    chk("mid_rst_nothing", dcyc.size(), d0);
    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      bus.req_valid = $urandom_range(0, 9) < 7;
      bus.req_pc = $urandom() & ~32'h3;
      bus.iwaitrequest = $urandom_range(0, 9) < 3;
      bus.instr_ready = $urandom_range(0, 9) < 7;
      bus.flush = $urandom_range(0, 49) == 0;
      lat = $urandom_range(1, 4);
      tick();
    end
    settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
